// File: rtl/rgb_pwm.sv
// rgb_pwm: three-channel LED PWM driven from a packed 24-bit colour word.
// A shared divider and 255-step phase counter define the period. Each
// channel latches its duty (optionally slew-limited) only at the period
// boundary, so a colour change can never produce a glitched period.

module rgb_pwm_ch #(
   parameter int SLEW   = 0,
   parameter int INVERT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       boundary,
   input  logic [7:0] phase,
   input  logic [7:0] target,
   output logic [7:0] duty,
   output logic       pwm
);
   localparam logic INV = (INVERT != 0);

   logic [8:0] t9, d9, diff, step, slew9;
   logic [7:0] nxt;

   // Next duty: jump straight to target, or move toward it by at most SLEW.
   // 9-bit arithmetic keeps the intermediate from wrapping.
   always_comb begin
      t9    = {1'b0, target};
      d9    = {1'b0, duty};
      slew9 = 9'(SLEW);
      diff  = 9'd0;
      step  = 9'd0;
      nxt   = duty;
      if (SLEW == 0) begin
         nxt = target;
      end else if (t9 > d9) begin
         diff = t9 - d9;
         step = (diff > slew9) ? slew9 : diff;
         nxt  = 8'(d9 + step);
      end else if (t9 < d9) begin
         diff = d9 - t9;
         step = (diff > slew9) ? slew9 : diff;
         nxt  = 8'(d9 - step);
      end
   end

   // Duty register: only updated at the period boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           duty <= 8'd0;
      else if (boundary) duty <= nxt;
   end

   // Registered output; phase tops out at 254 so duty 255 is solid on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pwm <= INV;
      else     pwm <= (phase < duty) ^ INV;
   end
endmodule

module rgb_pwm #(
   parameter int CLK_DIV = 98,
   parameter int SLEW    = 0,
   parameter int INVERT  = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] data,
   output logic [2:0]  pwm,
   output logic [23:0] duty,
   output logic        period_start
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div_cnt;
   logic [7:0]    phase;
   logic          tick, boundary;

   assign tick     = (div_cnt == DW'(CLK_DIV - 1));
   assign boundary = tick && (phase == 8'd254);

   // Clock divider producing one tick every CLK_DIV cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + 1'b1;
   end

   // Phase counter 0..254, wrapping at the boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           phase <= 8'd0;
      else if (boundary) phase <= 8'd0;
      else if (tick)     phase <= phase + 8'd1;
   end

   // Boundary pulse, aligned with phase 0 and the freshly loaded duties.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) period_start <= 1'b0;
      else     period_start <= boundary;
   end

   for (genvar c = 0; c < 3; c++) begin : g_ch
      rgb_pwm_ch #(.SLEW(SLEW), .INVERT(INVERT)) u_ch (
         .clk      (clk),
         .rst      (rst),
         .boundary (boundary),
         .phase    (phase),
         .target   (data[8*c +: 8]),
         .duty     (duty[8*c +: 8]),
         .pwm      (pwm[c])
      );
   end
endmodule

// File: tb/tb_rgb_pwm.sv
// Bench for rgb_pwm: three instances (plain, slew-limited, inverted), all
// with CLK_DIV=2, so one period is 510 clocks.
module tb_rgb_pwm;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] data_s [3];
   logic [2:0]  pwm_s  [3];
   logic [23:0] duty_s [3];
   logic        ps_s   [3];

   int total = 0;
   int bad   = 0;

   logic [23:0] exp_q [$];
   int          cnt_q [$];

   always #5 clk = ~clk;

   rgb_pwm #(.CLK_DIV(2), .SLEW(0), .INVERT(0)) dut0 (
      .clk(clk), .rst(rst), .data(data_s[0]), .pwm(pwm_s[0]),
      .duty(duty_s[0]), .period_start(ps_s[0]));
   rgb_pwm #(.CLK_DIV(2), .SLEW(16), .INVERT(0)) dut1 (
      .clk(clk), .rst(rst), .data(data_s[1]), .pwm(pwm_s[1]),
      .duty(duty_s[1]), .period_start(ps_s[1]));
   rgb_pwm #(.CLK_DIV(2), .SLEW(0), .INVERT(1)) dut2 (
      .clk(clk), .rst(rst), .data(data_s[2]), .pwm(pwm_s[2]),
      .duty(duty_s[2]), .period_start(ps_s[2]));

   // Count clock edges until period_start is seen (sampled on negedge).
   task automatic wait_ps(input int w, input int limit, output int n, output bit found);
      found = 1'b0;
      n = 0;
      while (!found && n < limit) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (ps_s[w]) found = 1'b1;
      end
   endtask

   // Sample one full period starting just after a period_start; optional
   // data changes are driven right after edges at1 / at2.
   task automatic measure(input int w, input int at1, input logic [23:0] v1,
                          input int at2, input logic [23:0] v2,
                          output int hr, output int hg, output int hb, output bit span_ok);
      hr = 0; hg = 0; hb = 0; span_ok = 1'b1;
      for (int i = 1; i <= 510; i++) begin
         @(posedge clk);
         #1;
         if (i == at1) data_s[w] = v1;
         if (i == at2) data_s[w] = v2;
         @(negedge clk);
         hr += int'(pwm_s[w][0]);
         hg += int'(pwm_s[w][1]);
         hb += int'(pwm_s[w][2]);
         if (i < 510 && ps_s[w]) span_ok = 1'b0;
         if (i == 510 && !ps_s[w]) span_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      int n, errs, ec;
      bit found;
      logic [23:0] ed;
      rst = 1'b1;
      data_s[0] = 24'hFFFFFF;
      data_s[1] = 24'h0;
      data_s[2] = 24'h0;
      repeat (3) @(negedge clk);
      total++; if (pwm_s[0] !== 3'b000) begin bad++; $display("FAIL reset_pwm got=%b want=000", pwm_s[0]); end
      total++; if (duty_s[0] !== 24'h0) begin bad++; $display("FAIL reset_duty got=%h want=000000", duty_s[0]); end
      total++; if (ps_s[0] !== 1'b0) begin bad++; $display("FAIL reset_ps got=%b want=0", ps_s[0]); end
      total++; if (pwm_s[2] !== 3'b111) begin bad++; $display("FAIL reset_pwm_inv got=%b want=111", pwm_s[2]); end
      exp_q.push_back(24'hFFFFFF);
      cnt_q.push_back(510);
      rst = 1'b0;
      wait_ps(0, 2000, n, found);
      ec = cnt_q.pop_front();
      ed = exp_q.pop_front();
      total++; if (!found || n !== ec) begin bad++; $display("FAIL first_boundary got=%0d want=%0d", n, ec); end
      total++; if (duty_s[0] !== ed) begin bad++; $display("FAIL first_duty got=%h want=%h", duty_s[0], ed); end
      errs = 0;
      repeat (600) begin
         @(posedge clk);
         @(negedge clk);
         if (pwm_s[0] !== 3'b111) errs++;
      end
      total++; if (errs !== 0) begin bad++; $display("FAIL full_on got=%0d bad cycles want=0", errs); end
   endtask

   task automatic test_duty();
      int n, hr, hg, hb;
      bit found, span_ok;
      data_s[0] = 24'h800100;
      wait_ps(0, 1100, n, found);
      total++; if (!found || duty_s[0] !== 24'h800100) begin bad++; $display("FAIL duty_load got=%h want=800100", duty_s[0]); end
      cnt_q.push_back(0); cnt_q.push_back(2); cnt_q.push_back(256);
      measure(0, -1, 24'h0, -1, 24'h0, hr, hg, hb, span_ok);
      n = cnt_q.pop_front();
      total++; if (hr !== n) begin bad++; $display("FAIL duty_r got=%0d want=%0d", hr, n); end
      n = cnt_q.pop_front();
      total++; if (hg !== n) begin bad++; $display("FAIL duty_g got=%0d want=%0d", hg, n); end
      n = cnt_q.pop_front();
      total++; if (hb !== n) begin bad++; $display("FAIL duty_b got=%0d want=%0d", hb, n); end
      total++; if (!span_ok) begin bad++; $display("FAIL duty_span got=bad spacing want=510"); end
   endtask

   task automatic test_boundary_latch();
      int n, hr, hg, hb;
      bit found, span_ok;
      data_s[0] = 24'h00000A;
      wait_ps(0, 1100, n, found);
      cnt_q.push_back(20); cnt_q.push_back(400); cnt_q.push_back(400); cnt_q.push_back(100);
      // mid-period change to 200 must not affect this period
      measure(0, 255, 24'h0000C8, -1, 24'h0, hr, hg, hb, span_ok);
      n = cnt_q.pop_front();
      total++; if (!found || hr !== n || !span_ok) begin bad++; $display("FAIL latch_cur got=%0d want=%0d", hr, n); end
      // one-cycle glitch to 5 mid-period
      measure(0, 100, 24'h000005, 101, 24'h0000C8, hr, hg, hb, span_ok);
      n = cnt_q.pop_front();
      total++; if (hr !== n) begin bad++; $display("FAIL latch_next got=%0d want=%0d", hr, n); end
      // change in the boundary cycle itself is taken
      measure(0, 509, 24'h000032, -1, 24'h0, hr, hg, hb, span_ok);
      n = cnt_q.pop_front();
      total++; if (hr !== n) begin bad++; $display("FAIL latch_glitch got=%0d want=%0d", hr, n); end
      total++; if (duty_s[0] !== 24'h000032) begin bad++; $display("FAIL latch_bnd_duty got=%h want=000032", duty_s[0]); end
      measure(0, -1, 24'h0, -1, 24'h0, hr, hg, hb, span_ok);
      n = cnt_q.pop_front();
      total++; if (hr !== n) begin bad++; $display("FAIL latch_bnd_cnt got=%0d want=%0d", hr, n); end
   endtask

   task automatic test_slew();
      int n, d;
      bit found;
      logic [23:0] ed;
      d = 0;
      data_s[1] = 24'h0000FF;
      for (int k = 0; k < 18; k++) begin
         if (255 - d > 16) d += 16; else d = 255;
         exp_q.push_back(24'(d));
      end
      while (exp_q.size() > 0) begin
         wait_ps(1, 1100, n, found);
         ed = exp_q.pop_front();
         total++; if (!found || duty_s[1] !== ed) begin bad++; $display("FAIL slew_up got=%h want=%h", duty_s[1], ed); end
      end
      data_s[1] = 24'h0;
      for (int k = 0; k < 17; k++) begin
         if (d > 16) d -= 16; else d = 0;
         exp_q.push_back(24'(d));
      end
      while (exp_q.size() > 0) begin
         wait_ps(1, 1100, n, found);
         ed = exp_q.pop_front();
         total++; if (!found || duty_s[1] !== ed) begin bad++; $display("FAIL slew_down got=%h want=%h", duty_s[1], ed); end
      end
   endtask

   task automatic test_invert();
      int n, hr, hg, hb;
      bit found, span_ok;
      data_s[2] = 24'h0000FF;
      wait_ps(2, 1100, n, found);
      cnt_q.push_back(0); cnt_q.push_back(510); cnt_q.push_back(510);
      measure(2, -1, 24'h0, -1, 24'h0, hr, hg, hb, span_ok);
      n = cnt_q.pop_front();
      total++; if (!found || hr !== n) begin bad++; $display("FAIL inv_r got=%0d want=%0d", hr, n); end
      n = cnt_q.pop_front();
      total++; if (hg !== n) begin bad++; $display("FAIL inv_g got=%0d want=%0d", hg, n); end
      n = cnt_q.pop_front();
      total++; if (hb !== n) begin bad++; $display("FAIL inv_b got=%0d want=%0d", hb, n); end
   endtask

   task automatic test_mid_reset();
      int n, nz, ec;
      bit found;
      data_s[0] = 24'h000080;
      wait_ps(0, 1100, n, found);
      repeat (20) @(negedge clk);
      total++; if (!found || pwm_s[0] !== 3'b001) begin bad++; $display("FAIL mrst_pre got=%b want=001", pwm_s[0]); end
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      total++; if (pwm_s[0] !== 3'b000) begin bad++; $display("FAIL mrst_pwm got=%b want=000", pwm_s[0]); end
      total++; if (duty_s[0] !== 24'h0) begin bad++; $display("FAIL mrst_duty got=%h want=000000", duty_s[0]); end
      total++; if (pwm_s[2] !== 3'b111) begin bad++; $display("FAIL mrst_pwm_inv got=%b want=111", pwm_s[2]); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cnt_q.push_back(510);
      nz = 0; n = 0; found = 1'b0;
      while (!found && n < 2000) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (ps_s[0]) found = 1'b1;
         else if (duty_s[0] !== 24'h0) nz++;
      end
      ec = cnt_q.pop_front();
      total++; if (!found || n !== ec) begin bad++; $display("FAIL mrst_boundary got=%0d want=%0d", n, ec); end
      total++; if (nz !== 0) begin bad++; $display("FAIL mrst_duty_hold got=%0d nonzero want=0", nz); end
      total++; if (duty_s[0] !== 24'h000080) begin bad++; $display("FAIL mrst_reload got=%h want=000080", duty_s[0]); end
   endtask

   initial begin
      test_reset();
      test_duty();
      test_boundary_latch();
      test_slew();
      test_invert();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
